// File: rtl/stream_mux_pkt.sv
// stream_mux_pkt: registered NUM_CH:1 valid/ready stream mux with packet lock.
// A routing decision is made only in IDLE (from sel). It is then held until the
// beat carrying in_last is accepted, and every other input is backpressured.
// Optional feature macro: STREAM_MUX_SEL_CHECK_EN (adds the registered sel_err output).
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   sel                 requested channel, sampled only in IDLE
//   in_data/valid/last  per-channel streams; channel i at [i*WIDTH +: WIDTH]
//   in_ready            per-channel ready (combinational from state and out_ready)
//   out_data/valid/last registered output beat
//   out_ready           downstream ready
//   busy                1 while a packet is open
//   sel_err             registered out-of-range sel flag (macro only)
module stream_mux_pkt #(
   parameter  int unsigned NUM_CH = 4,
   parameter  int unsigned WIDTH  = 8,
   localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       in_last,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic                    out_last,
   input  logic                    out_ready,
`ifdef STREAM_MUX_SEL_CHECK_EN
   output logic                    sel_err,
`endif
   output logic                    busy
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PKT  = 1'b1
   } state_t;

   state_t             r_state;
   logic [SEL_W-1:0]   r_cur_sel;
   logic [WIDTH-1:0]   r_out_data;
   logic               r_out_valid;
   logic               r_out_last;
   logic               r_busy;

   state_t             w_state_nxt;
   logic [SEL_W-1:0]   w_cur_sel_nxt;
   logic [WIDTH-1:0]   w_out_data_nxt;
   logic               w_out_valid_nxt;
   logic               w_out_last_nxt;
   logic               w_load_ok;
   logic [SEL_W-1:0]   w_route;
   logic               w_route_ok;
   logic [NUM_CH-1:0]  w_in_ready;
   logic               w_xfer;
   logic [WIDTH-1:0]   w_xdata;
   logic               w_xlast;

`ifdef STREAM_MUX_SEL_CHECK_EN
   logic r_sel_err;
   logic w_sel_err_nxt;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cur_sel   <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
`ifdef STREAM_MUX_SEL_CHECK_EN
         r_sel_err   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_cur_sel   <= w_cur_sel_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_last  <= w_out_last_nxt;
         r_busy      <= (w_state_nxt == S_PKT);
`ifdef STREAM_MUX_SEL_CHECK_EN
         r_sel_err   <= w_sel_err_nxt;
`endif
      end
   end

   // Routing, handshake and next-state logic
   always_comb begin
      w_state_nxt     = r_state;
      w_cur_sel_nxt   = r_cur_sel;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
      w_out_last_nxt  = r_out_last;
      w_in_ready      = '0;
      w_xfer          = 1'b0;
      w_xdata         = '0;
      w_xlast         = 1'b0;

      w_load_ok  = !r_out_valid || out_ready;
      w_route    = (r_state == S_IDLE) ? sel : r_cur_sel;
      // rst_n gating keeps every ready low while reset is asserted
      w_route_ok = rst_n && (32'(w_route) < NUM_CH) && w_load_ok;

      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_in_ready[i] = w_route_ok && (w_route == SEL_W'(i));
         if (w_in_ready[i] && in_valid[i]) begin
            w_xfer  = 1'b1;
            w_xdata = in_data[i*WIDTH +: WIDTH];
            w_xlast = in_last[i];
         end
      end

      if (w_xfer) begin
         w_out_data_nxt  = w_xdata;
         w_out_last_nxt  = w_xlast;
         w_out_valid_nxt = 1'b1;
         if (r_state == S_IDLE && !w_xlast) begin
            w_state_nxt   = S_PKT;
            w_cur_sel_nxt = sel;
         end else if (r_state == S_PKT && w_xlast) begin
            w_state_nxt   = S_IDLE;
         end
      end else if (out_ready) begin
         w_out_valid_nxt = 1'b0;
      end
   end

`ifdef STREAM_MUX_SEL_CHECK_EN
   // Flags an unroutable request while waiting for a packet
   always_comb begin
      w_sel_err_nxt = (r_state == S_IDLE) && (32'(sel) >= NUM_CH);
   end
   assign sel_err = r_sel_err;
`endif

   assign in_ready  = w_in_ready;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign busy      = r_busy;

endmodule
